// File: rtl/hex_cpu_core.sv
// Multi-cycle Hex core: 8-bit instructions, 32-bit data, shared 1-cycle-latency memory.
// Define HEX_TRACE_EN to print a per-instruction trace line in simulation.
module hex_cpu_core #(
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    output logic                  o_f_valid,
    output logic [ADDR_WIDTH+1:0] o_f_addr,
    input  logic [7:0]            i_f_data,
    output logic                  o_d_valid,
    output logic                  o_d_we,
    output logic [ADDR_WIDTH-1:0] o_d_addr,
    output logic [31:0]           o_d_data,
    input  logic [31:0]           i_d_data,
    output logic                  o_syscall_valid,
    output logic [1:0]            o_syscall
);
    localparam int PCW = ADDR_WIDTH + 2;

    typedef enum logic [1:0] {S_FETCH, S_EXEC, S_LOAD, S_HALT} state_t;

    state_t           state_q, state_d;
    logic [PCW-1:0]   pc_q, pc_d;
    logic [31:0]      areg_q, areg_d;
    logic [31:0]      breg_q, breg_d;
    logic [31:0]      oreg_q, oreg_d;
    logic             ld_b_q, ld_b_d;

    logic [3:0]       op;
    logic [31:0]      oreg_eff;
    logic [PCW-1:0]   pc_inc;
    logic [PCW-1:0]   br_tgt;
    logic [31:0]      ind_a;
    logic [31:0]      ind_b;

    assign op       = i_f_data[7:4];
    assign oreg_eff = oreg_q | {28'd0, i_f_data[3:0]};
    assign pc_inc   = pc_q + PCW'(1);
    assign br_tgt   = pc_inc + oreg_eff[PCW-1:0];
    assign ind_a    = areg_q + oreg_eff;
    assign ind_b    = breg_q + oreg_eff;

    always_comb begin
        state_d         = state_q;
        pc_d            = pc_q;
        areg_d          = areg_q;
        breg_d          = breg_q;
        oreg_d          = oreg_q;
        ld_b_d          = ld_b_q;
        o_f_valid       = 1'b0;
        o_f_addr        = pc_q;
        o_d_valid       = 1'b0;
        o_d_we          = 1'b0;
        o_d_addr        = '0;
        o_d_data        = areg_q;
        o_syscall_valid = 1'b0;
        o_syscall       = 2'd0;

        unique case (state_q)
            S_FETCH: begin
                o_f_valid = 1'b1;
                state_d   = S_EXEC;
            end
            S_EXEC: begin
                pc_d    = pc_inc;
                oreg_d  = '0;
                state_d = S_FETCH;
                case (op)
                    4'h0, 4'h1: begin
                        o_d_valid = 1'b1;
                        o_d_addr  = oreg_eff[ADDR_WIDTH-1:0];
                        ld_b_d    = op[0];
                        state_d   = S_LOAD;
                    end
                    4'h2: begin
                        o_d_valid = 1'b1;
                        o_d_we    = 1'b1;
                        o_d_addr  = oreg_eff[ADDR_WIDTH-1:0];
                    end
                    4'h3: areg_d = oreg_eff;
                    4'h4: breg_d = oreg_eff;
                    4'h5: areg_d = {{(32-PCW){1'b0}}, pc_inc} + oreg_eff;
                    4'h6: begin
                        o_d_valid = 1'b1;
                        o_d_addr  = ind_a[ADDR_WIDTH-1:0];
                        ld_b_d    = 1'b0;
                        state_d   = S_LOAD;
                    end
                    4'h7: begin
                        o_d_valid = 1'b1;
                        o_d_addr  = ind_b[ADDR_WIDTH-1:0];
                        ld_b_d    = 1'b1;
                        state_d   = S_LOAD;
                    end
                    4'h8: begin
                        o_d_valid = 1'b1;
                        o_d_we    = 1'b1;
                        o_d_addr  = ind_b[ADDR_WIDTH-1:0];
                    end
                    4'h9: pc_d = br_tgt;
                    4'hA: if (areg_q == 32'd0) pc_d = br_tgt;
                    4'hB: if (areg_q[31]) pc_d = br_tgt;
                    4'hD: begin
                        case (oreg_eff)
                            32'd0: pc_d = breg_q[PCW-1:0];
                            32'd1: areg_d = areg_q + breg_q;
                            32'd2: areg_d = areg_q - breg_q;
                            32'd3: begin
                                o_syscall_valid = 1'b1;
                                o_syscall       = areg_q[1:0];
                                if (areg_q[1:0] == 2'd0) state_d = S_HALT;
                            end
                            default: ;
                        endcase
                    end
                    4'hE: oreg_d = oreg_eff << 4;
                    4'hF: oreg_d = 32'hFFFF_FF00 | (oreg_eff << 4);
                    default: ;
                endcase
            end
            S_LOAD: begin
                if (ld_b_q) breg_d = i_d_data;
                else        areg_d = i_d_data;
                state_d = S_FETCH;
            end
            default: state_d = S_HALT;
        endcase

        // Requests stay quiet while reset is held so the memory sees nothing spurious.
        if (i_rst) begin
            o_f_valid       = 1'b0;
            o_d_valid       = 1'b0;
            o_d_we          = 1'b0;
            o_syscall_valid = 1'b0;
            o_syscall       = 2'd0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_FETCH;
            pc_q    <= '0;
            areg_q  <= '0;
            breg_q  <= '0;
            oreg_q  <= '0;
            ld_b_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            areg_q  <= areg_d;
            breg_q  <= breg_d;
            oreg_q  <= oreg_d;
            ld_b_q  <= ld_b_d;
        end
    end

`ifdef HEX_TRACE_EN
    function automatic string mnem(input logic [3:0] o);
        case (o)
            4'h0: return "LDAM";
            4'h1: return "LDBM";
            4'h2: return "STAM";
            4'h3: return "LDAC";
            4'h4: return "LDBC";
            4'h5: return "LDAP";
            4'h6: return "LDAI";
            4'h7: return "LDBI";
            4'h8: return "STAI";
            4'h9: return "BR";
            4'hA: return "BRZ";
            4'hB: return "BRN";
            4'hC: return "NOP";
            4'hD: return "OPR";
            4'hE: return "PFIX";
            default: return "NFIX";
        endcase
    endfunction

    always_ff @(posedge i_clk) begin
        if (!i_rst && state_q == S_EXEC)
            $display("%0t pc=%h %s oreg_eff=%h areg=%h breg=%h",
                     $time, pc_q, mnem(op), oreg_eff, areg_q, breg_q);
    end
`endif
endmodule

// File: tb/tb_hex_cpu_core.sv
// Directed bench for hex_cpu_core: small programs with hand-computed results,
// beside a 1-cycle-latency memory model.
module tb_hex_cpu_core;
    localparam int AW = 16;

    logic          clk = 1'b0;
    logic          i_rst = 1'b1;
    logic          o_f_valid;
    logic [AW+1:0] o_f_addr;
    logic [7:0]    i_f_data;
    logic          o_d_valid;
    logic          o_d_we;
    logic [AW-1:0] o_d_addr;
    logic [31:0]   o_d_data;
    logic [31:0]   i_d_data;
    logic          o_syscall_valid;
    logic [1:0]    o_syscall;

    logic [7:0]    imem [0:63];
    logic [31:0]   dmem [0:31];

    logic [AW+1:0] fq[$];
    logic [48:0]   dq[$];
    logic [1:0]    sq[$];
    logic          both_seen = 1'b0;
    int            fb, db, sb;
    int            n_cmp = 0;
    int            n_err = 0;

    always #5 clk = ~clk;

    hex_cpu_core #(.ADDR_WIDTH(AW)) dut (
        .i_clk(clk), .i_rst(i_rst),
        .o_f_valid(o_f_valid), .o_f_addr(o_f_addr), .i_f_data(i_f_data),
        .o_d_valid(o_d_valid), .o_d_we(o_d_we), .o_d_addr(o_d_addr),
        .o_d_data(o_d_data), .i_d_data(i_d_data),
        .o_syscall_valid(o_syscall_valid), .o_syscall(o_syscall)
    );

    always @(posedge clk) begin
        i_f_data <= imem[o_f_addr[5:0]];
        if (o_d_valid && !o_d_we) i_d_data <= dmem[o_d_addr[4:0]];
    end

    always @(negedge clk) begin
        if (!i_rst) begin
            if (o_f_valid) fq.push_back(o_f_addr);
            if (o_d_valid) dq.push_back({o_d_we, o_d_addr, o_d_data});
            if (o_syscall_valid) sq.push_back(o_syscall);
            if (o_f_valid && o_d_valid) both_seen <= 1'b1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [AW+1:0] fat(input int i);
        return (i < fq.size()) ? fq[i] : '1;
    endfunction
    function automatic logic [48:0] dat(input int i);
        return (i < dq.size()) ? dq[i] : '1;
    endfunction
    function automatic logic [1:0] sat(input int i);
        return (i < sq.size()) ? sq[i] : 2'bxx;
    endfunction

    task automatic run(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rst_on();
        @(posedge clk);
        #1 i_rst = 1'b1;
        for (int i = 0; i < 64; i++) imem[i] = 8'hC0;
        for (int i = 0; i < 32; i++) dmem[i] = 32'd0;
        @(posedge clk);
        #1;
    endtask

    task automatic rst_off(input string tag);
        chk({tag, "_rst_pc"},   64'(dut.pc_q),   64'd0);
        chk({tag, "_rst_a"},    64'(dut.areg_q), 64'd0);
        chk({tag, "_rst_b"},    64'(dut.breg_q), 64'd0);
        chk({tag, "_rst_o"},    64'(dut.oreg_q), 64'd0);
        chk({tag, "_rst_req"},  64'({o_f_valid, o_d_valid, o_d_we, o_syscall_valid, o_syscall}), 64'd0);
        fb = fq.size();
        db = dq.size();
        sb = sq.size();
        i_rst = 1'b0;
    endtask

    initial begin
        // LDAC 5; LDBC 3; ADD; SUB; BRB
        rst_on();
        imem[0] = 8'h35; imem[1] = 8'h43; imem[2] = 8'hD1; imem[3] = 8'hD2; imem[4] = 8'hD0;
        rst_off("t1");
        run(6);
        chk("add_a", 64'(dut.areg_q), 64'd8);
        chk("add_b", 64'(dut.breg_q), 64'd3);
        chk("add_nf", 64'(fq.size() - fb), 64'd3);
        chk("add_f", 64'({fat(fb), fat(fb+1), fat(fb+2)}), 64'({18'd0, 18'd1, 18'd2}));
        run(2);
        chk("sub_a", 64'(dut.areg_q), 64'd5);
        run(2);
        chk("brb_pc", 64'(dut.pc_q), 64'd3);

        // PFIX 1; LDAC 2; NFIX F; LDAC E; LDAP 3
        rst_on();
        imem[0] = 8'hE1; imem[1] = 8'h32; imem[2] = 8'hFF; imem[3] = 8'h3E; imem[4] = 8'h53;
        rst_off("t2");
        run(2);
        chk("pfix_o", 64'(dut.oreg_q), 64'h10);
        run(2);
        chk("pfix_a", 64'(dut.areg_q), 64'h12);
        chk("pfix_clr", 64'(dut.oreg_q), 64'd0);
        run(2);
        chk("nfix_o", 64'(dut.oreg_q), 64'hFFFF_FFF0);
        run(2);
        chk("nfix_a", 64'(dut.areg_q), 64'hFFFF_FFFE);
        run(2);
        chk("ldap_a", 64'(dut.areg_q), 64'd8);

        // LDAM 7; STAM 9
        rst_on();
        dmem[7] = 32'hABCD;
        imem[0] = 8'h07; imem[1] = 8'h29;
        rst_off("t3");
        run(3);
        chk("ldam_a", 64'(dut.areg_q), 64'hABCD);
        run(2);
        chk("ld_req", 64'(dat(db)), 64'({1'b0, 16'd7, 32'd0}));
        chk("st_req", 64'(dat(db+1)), 64'({1'b1, 16'd9, 32'hABCD}));
        chk("ld_nd", 64'(dq.size() - db), 64'd2);

        // BR 9 to pc 10; BRZ 4 taken with areg=0
        rst_on();
        imem[0] = 8'h99; imem[10] = 8'hA4;
        rst_off("t4");
        run(5);
        chk("brz_t", 64'({fat(fb), fat(fb+1), fat(fb+2)}), 64'({18'd0, 18'd10, 18'd15}));

        // LDAC 1; BR 8; BRZ 4 not taken
        rst_on();
        imem[0] = 8'h31; imem[1] = 8'h98; imem[10] = 8'hA4;
        rst_off("t5");
        run(7);
        chk("brz_nt", 64'({fat(fb), fat(fb+1), fat(fb+2), fat(fb+3)}),
            64'({18'd0, 18'd1, 18'd10, 18'd11}));

        // areg=0x80000000 via LDAM; BRN 2 at pc 3
        rst_on();
        dmem[0] = 32'h8000_0000;
        imem[0] = 8'h00; imem[3] = 8'hB2;
        rst_off("t6");
        run(10);
        chk("brn_a", 64'(dut.areg_q), 64'h8000_0000);
        chk("brn_f", 64'({fat(fb+3), fat(fb+4)}), 64'({18'd3, 18'd6}));

        // SVC WRITE continues; SVC EXIT halts
        rst_on();
        imem[0] = 8'h31; imem[1] = 8'hD3; imem[2] = 8'h30; imem[3] = 8'hD3;
        rst_off("t7");
        run(8);
        run(6);
        chk("svc_n", 64'(sq.size() - sb), 64'd2);
        chk("svc_codes", 64'({sat(sb), sat(sb+1)}), 64'({2'd1, 2'd0}));
        chk("halt_nf", 64'(fq.size() - fb), 64'd4);
        chk("halt_nd", 64'(dq.size() - db), 64'd0);

        // Reset during LOAD abandons the write-back
        rst_on();
        dmem[7] = 32'h55;
        imem[0] = 8'h35; imem[1] = 8'h07;
        rst_off("t8");
        run(4);
        chk("mid_pre_a", 64'(dut.areg_q), 64'd5);
        i_rst = 1'b1;
        run(1);
        rst_off("t8b");
        run(1);
        chk("mid_f0", 64'(fat(fb)), 64'd0);
        run(2);
        chk("mid_a", 64'(dut.areg_q), 64'd5);

        chk("excl", 64'(both_seen), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
